// File: rtl/mips_pkg.sv
// Shared types for the MIPS32 memory stage: FSM state encoding, datapath
// constants and the EX/MEM and MEM/WB pipeline register layouts.
package mips_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [0:0] {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

  // Contents of the EX/MEM register (the _m signals).
  typedef struct packed {
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   write_data;
    logic [REG_AW-1:0] write_reg;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch;
    logic              zero;
    logic [XLEN-1:0]   pc_branch;
  } ex_mem_t;

  // Contents of the MEM/WB register (the _w signals).
  typedef struct packed {
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   read_data;
    logic [REG_AW-1:0] write_reg;
    logic              reg_write;
    logic              mem_to_reg;
    logic              addr_err;
  } mem_wb_t;

  // A word access is misaligned when either of the two low address bits is set.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake controller: tracks an outstanding access, drives the
// request line, raises the upstream stall and counts stalled cycles.
module mem_access_fsm #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_op,
  input  logic                   dmem_ready,
  output logic                   dmem_req,
  output logic                   stall_m,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  import mips_pkg::*;

  mem_state_t             state_r;
  mem_state_t             next_state_s;
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= M_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and request generation; a zero-wait memory keeps us in M_IDLE.
  always_comb begin
    next_state_s = state_r;
    dmem_req     = 1'b0;
    case (state_r)
      M_IDLE: begin
        dmem_req = mem_op;
        if (mem_op && !dmem_ready) begin
          next_state_s = M_WAIT;
        end else begin
          next_state_s = M_IDLE;
        end
      end
      M_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          next_state_s = M_IDLE;
        end else begin
          next_state_s = M_WAIT;
        end
      end
      default: begin
        next_state_s = M_IDLE;
        dmem_req     = 1'b0;
      end
    endcase
  end

  assign stall_m = mem_op & dmem_req & ~dmem_ready;

  // Saturating count of cycles spent stalled on memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (stall_m && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory stage: EX/MEM register, data-memory access with stall,
// branch resolution and the MEM/WB register.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned word accesses are not
// issued to memory and are flagged on addr_err_w instead.
module mem_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      alu_out_e,
  input  logic [DATA_W-1:0]      write_data_e,
  input  logic [REG_AW-1:0]      write_reg_e,
  input  logic                   reg_write_e,
  input  logic                   mem_to_reg_e,
  input  logic                   mem_write_e,
  input  logic                   branch_e,
  input  logic                   zero_e,
  input  logic [DATA_W-1:0]      pc_branch_e,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DATA_W-1:0]      dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  input  logic                   dmem_ready,
  input  logic [DATA_W-1:0]      dmem_rdata,
  output logic                   stall_m,
  output logic                   pc_src_m,
  output logic [DATA_W-1:0]      pc_branch_m,
  output logic [DATA_W-1:0]      alu_out_w,
  output logic [DATA_W-1:0]      read_data_w,
  output logic [REG_AW-1:0]      write_reg_w,
  output logic                   reg_write_w,
  output logic                   mem_to_reg_w,
  output logic                   addr_err_w,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  import mips_pkg::*;

  ex_mem_t ex_mem_s;
  ex_mem_t ex_mem_r;
  mem_wb_t mem_wb_r;
  logic    mem_op_s;
  logic    misaligned_s;
  logic    access_op_s;

  // Gather the execute-stage inputs into the EX/MEM record.
  always_comb begin
    ex_mem_s            = '0;
    ex_mem_s.alu_out    = alu_out_e;
    ex_mem_s.write_data = write_data_e;
    ex_mem_s.write_reg  = write_reg_e;
    ex_mem_s.reg_write  = reg_write_e;
    ex_mem_s.mem_to_reg = mem_to_reg_e;
    ex_mem_s.mem_write  = mem_write_e;
    ex_mem_s.branch     = branch_e;
    ex_mem_s.zero       = zero_e;
    ex_mem_s.pc_branch  = pc_branch_e;
  end

  // EX/MEM register: frozen while memory is stalling so the request stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_r <= '0;
    end else if (!stall_m) begin
      ex_mem_r <= ex_mem_s;
    end else begin
      ex_mem_r <= ex_mem_r;
    end
  end

  assign mem_op_s = ex_mem_r.mem_to_reg | ex_mem_r.mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_s = mem_op_s & is_misaligned(ex_mem_r.alu_out[1:0]);
`else
  assign misaligned_s = 1'b0;
`endif

  // A faulting access is never presented to memory, so it cannot stall.
  assign access_op_s = mem_op_s & ~misaligned_s;

  mem_access_fsm #(
    .STALL_CNT_W (STALL_CNT_W)
  ) u_mem_access_fsm (
    .clk          (clk),
    .rst          (rst),
    .mem_op       (access_op_s),
    .dmem_ready   (dmem_ready),
    .dmem_req     (dmem_req),
    .stall_m      (stall_m),
    .stall_cycles (stall_cycles)
  );

  assign dmem_addr   = ex_mem_r.alu_out;
  assign dmem_wdata  = ex_mem_r.write_data;
  assign dmem_we     = ex_mem_r.mem_write;
  assign pc_src_m    = ex_mem_r.branch & ex_mem_r.zero;
  assign pc_branch_m = ex_mem_r.pc_branch;

  // MEM/WB register: bubble on stall, suppress the write of a faulting access,
  // capture load data on the ready cycle of a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_r <= '0;
    end else begin
      if (stall_m) begin
        mem_wb_r.reg_write  <= 1'b0;
        mem_wb_r.mem_to_reg <= 1'b0;
        mem_wb_r.addr_err   <= 1'b0;
      end else begin
        mem_wb_r.alu_out    <= ex_mem_r.alu_out;
        mem_wb_r.write_reg  <= ex_mem_r.write_reg;
        mem_wb_r.reg_write  <= ex_mem_r.reg_write & ~misaligned_s;
        mem_wb_r.mem_to_reg <= ex_mem_r.mem_to_reg;
        mem_wb_r.addr_err   <= misaligned_s;
      end
      if (dmem_ready && !dmem_we) begin
        mem_wb_r.read_data <= dmem_rdata;
      end else begin
        mem_wb_r.read_data <= mem_wb_r.read_data;
      end
    end
  end

  assign alu_out_w    = mem_wb_r.alu_out;
  assign read_data_w  = mem_wb_r.read_data;
  assign write_reg_w  = mem_wb_r.write_reg;
  assign reg_write_w  = mem_wb_r.reg_write;
  assign mem_to_reg_w = mem_wb_r.mem_to_reg;
  assign addr_err_w   = mem_wb_r.addr_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cycle table, then randomized
// traffic against a behavioural model, then alignment corner sequences.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] alu_out_e, write_data_e, pc_branch_e;
  logic [4:0]  write_reg_e;
  logic        reg_write_e, mem_to_reg_e, mem_write_e, branch_e, zero_e;
  logic        dmem_req, dmem_we, dmem_ready, stall_m, pc_src_m;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, pc_branch_m;
  logic [31:0] alu_out_w, read_data_w;
  logic [4:0]  write_reg_w;
  logic        reg_write_w, mem_to_reg_w, addr_err_w;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .zero_e(zero_e), .pc_branch_e(pc_branch_e),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_m(stall_m), .pc_src_m(pc_src_m), .pc_branch_m(pc_branch_m),
    .alu_out_w(alu_out_w), .read_data_w(read_data_w), .write_reg_w(write_reg_w),
    .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w), .addr_err_w(addr_err_w),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction as seen by the memory stage.
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw;
    logic        mtr;
    logic        mw;
    logic        br;
    logic        zr;
    logic [31:0] pcb;
  } ins_t;

  // Writeback-side view.
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    logic        rw;
    logic        mtr;
    logic        err;
  } wb_t;

  // Directed vector: inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic        rst;
    ins_t        e;
    logic        rdy;
    logic [31:0] rdata;
    logic        x_req;
    logic        x_stall;
    logic        x_pc;
    logic [31:0] x_pcb;
    logic [31:0] x_addr;
    logic [31:0] x_aluw;
    logic [31:0] x_rdw;
    logic [4:0]  x_wrw;
    logic        x_rww;
    logic        x_mtrw;
    logic [15:0] x_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                              input logic rw, input logic mtr, input logic mw,
                              input logic br, input logic zr, input logic [31:0] pcb);
    ins_t i;
    i.alu = alu; i.wd = wd; i.wr = wr; i.rw = rw; i.mtr = mtr; i.mw = mw;
    i.br = br; i.zr = zr; i.pcb = pcb;
    return i;
  endfunction

  task automatic drive(input ins_t e, input logic r, input logic rdy, input logic [31:0] rd);
    rst = r;
    alu_out_e = e.alu; write_data_e = e.wd; write_reg_e = e.wr;
    reg_write_e = e.rw; mem_to_reg_e = e.mtr; mem_write_e = e.mw;
    branch_e = e.br; zero_e = e.zr; pc_branch_e = e.pcb;
    dmem_ready = rdy; dmem_rdata = rd;
  endtask

  // ---------------- behavioural reference model ----------------
  ins_t        mm;   // instruction currently in the memory stage
  wb_t         mw;   // instruction currently in writeback
  int unsigned mcnt;

  function automatic logic is_mem(input ins_t i);
    return i.mtr | i.mw;
  endfunction

  function automatic logic is_bad(input ins_t i);
`ifdef MEM_ALIGN_CHECK_EN
    return is_mem(i) && (i.alu % 32'd4 != 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic wants_mem(input ins_t i);
    return is_mem(i) && !is_bad(i);
  endfunction

  // Apply one cycle: drive, advance the model by the clock edge, compare everything.
  task automatic tick(input ins_t e, input logic r, input logic rdy, input logic [31:0] rd);
    ins_t        nm;
    wb_t         nw;
    int unsigned ncnt;
    logic        stalled;
    drive(e, r, rdy, rd);
    if (r) begin
      nm = '0; nw = '0; ncnt = 0;
    end else begin
      stalled = wants_mem(mm) && !rdy;
      nw = mw;
      if (stalled) begin
        nw.rw = 1'b0; nw.mtr = 1'b0; nw.err = 1'b0;
        nm = mm;
        ncnt = (mcnt == 32'd65535) ? mcnt : mcnt + 1;
      end else begin
        nw.alu = mm.alu; nw.wr = mm.wr; nw.mtr = mm.mtr;
        nw.rw  = mm.rw && !is_bad(mm);
        nw.err = is_bad(mm);
        nm = e;
        ncnt = mcnt;
      end
      if (rdy && !mm.mw) nw.rd = rd;
    end
    @(posedge clk);
    #1;
    mm = nm; mw = nw; mcnt = ncnt;
    chk("dmem_req",     32'(dmem_req),     32'(wants_mem(mm)));
    chk("stall_m",      32'(stall_m),      32'(wants_mem(mm) && !rdy));
    chk("dmem_addr",    dmem_addr,         mm.alu);
    chk("dmem_wdata",   dmem_wdata,        mm.wd);
    chk("dmem_we",      32'(dmem_we),      32'(mm.mw));
    chk("pc_src_m",     32'(pc_src_m),     32'(mm.br && mm.zr));
    chk("pc_branch_m",  pc_branch_m,       mm.pcb);
    chk("alu_out_w",    alu_out_w,         mw.alu);
    chk("read_data_w",  read_data_w,       mw.rd);
    chk("write_reg_w",  32'(write_reg_w),  32'(mw.wr));
    chk("reg_write_w",  32'(reg_write_w),  32'(mw.rw));
    chk("mem_to_reg_w", 32'(mem_to_reg_w), 32'(mw.mtr));
    chk("addr_err_w",   32'(addr_err_w),   32'(mw.err));
    chk("stall_cycles", 32'(stall_cycles), mcnt);
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    int   k;
    i = '0;
    k = $urandom_range(0, 4);
    i.wd  = $urandom;
    i.pcb = $urandom;
    i.wr  = 5'($urandom);
    i.zr  = 1'($urandom);
    i.alu = $urandom;
    case (k)
      0: i.rw = 1'b1;
      1: begin i.mtr = 1'b1; i.rw = 1'b1; end
      2: i.mw = 1'b1;
      3: i.br = 1'b1;
      default: i.rw = 1'b0;
    endcase
    if (is_mem(i) && $urandom_range(0, 7) != 0) i.alu = {i.alu[31:2], 2'b00};
    return i;
  endfunction

  vec_t vt[15];
  ins_t nop;
  ins_t alu_op;
  ins_t ld;

  initial begin
    nop = '0;
    alu_op = mk(32'h0000_0999, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    // rst, instruction, rdy, rdata | req, stall, pc_src, pc_branch, addr, alu_w, rdata_w, wreg_w, rw_w, mtr_w, cnt
    vt[0]  = '{1'b1, nop, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd0};
    vt[1]  = '{1'b0, mk(32'h7, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0), 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 32'h0, 32'h7, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd0};
    vt[2]  = '{1'b0, nop, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h7, 32'h0, 5'd3, 1'b1, 1'b0, 16'd0};
    vt[3]  = '{1'b0, mk(32'h100, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0), 1'b1, 32'h0,
               1'b1, 1'b0, 1'b0, 32'h0, 32'h100, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd0};
    vt[4]  = '{1'b0, nop, 1'b1, 32'hDEAD_BEEF,
               1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b1, 16'd0};
    vt[5]  = '{1'b0, mk(32'h20, 32'h55, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0), 1'b0, 32'h0,
               1'b1, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 16'd0};
    vt[6]  = '{1'b0, alu_op, 1'b0, 32'h0,
               1'b1, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 16'd1};
    vt[7]  = '{1'b0, alu_op, 1'b0, 32'h0,
               1'b1, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 16'd2};
    vt[8]  = '{1'b0, alu_op, 1'b1, 32'h1234_5678,
               1'b0, 1'b0, 1'b0, 32'h0, 32'h999, 32'h20, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 16'd2};
    vt[9]  = '{1'b0, mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0040), 1'b0, 32'h0,
               1'b0, 1'b0, 1'b1, 32'h0040_0040, 32'h0, 32'h999, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 16'd2};
    vt[10] = '{1'b0, mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0040_0080), 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 32'h0040_0080, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 16'd2};
    vt[11] = '{1'b0, mk(32'h44, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1000), 1'b0, 32'h0,
               1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h44, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 16'd2};
    vt[12] = '{1'b0, nop, 1'b0, 32'h0,
               1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h44, 32'h0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 16'd3};
    vt[13] = '{1'b1, nop, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd0};
    vt[14] = '{1'b0, nop, 1'b0, 32'h0,
               1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 16'd0};

    drive(nop, 1'b1, 1'b0, 32'h0);

    // Directed table: reset, ALU op, zero-wait load, waited store, branches,
    // branch held through a stall, reset while waiting.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].e, vt[i].rst, vt[i].rdy, vt[i].rdata);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i),    32'(dmem_req),     32'(vt[i].x_req));
      chk($sformatf("v%0d_stall", i),  32'(stall_m),      32'(vt[i].x_stall));
      chk($sformatf("v%0d_pcsrc", i),  32'(pc_src_m),     32'(vt[i].x_pc));
      chk($sformatf("v%0d_pcbr", i),   pc_branch_m,       vt[i].x_pcb);
      chk($sformatf("v%0d_addr", i),   dmem_addr,         vt[i].x_addr);
      chk($sformatf("v%0d_aluw", i),   alu_out_w,         vt[i].x_aluw);
      chk($sformatf("v%0d_rdw", i),    read_data_w,       vt[i].x_rdw);
      chk($sformatf("v%0d_wrw", i),    32'(write_reg_w),  32'(vt[i].x_wrw));
      chk($sformatf("v%0d_rww", i),    32'(reg_write_w),  32'(vt[i].x_rww));
      chk($sformatf("v%0d_mtrw", i),   32'(mem_to_reg_w), 32'(vt[i].x_mtrw));
      chk($sformatf("v%0d_err", i),    32'(addr_err_w),   32'h0);
      chk($sformatf("v%0d_cnt", i),    32'(stall_cycles), 32'(vt[i].x_cnt));
    end

    // Randomized traffic against the model, starting from reset.
    mm = '0; mw = '0; mcnt = 0;
    tick(nop, 1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 600; c++) begin
      tick(rand_ins(), ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), $urandom);
    end

    // Misaligned load at 0x102.
    tick(nop, 1'b1, 1'b0, 32'h0);
    ld = mk(32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    tick(ld, 1'b0, 1'b0, 32'h0);
    chk("align_req",   32'(dmem_req), 32'h0);
    chk("align_stall", 32'(stall_m),  32'h0);
    tick(nop, 1'b0, 1'b0, 32'h0);
    chk("align_err",   32'(addr_err_w),  32'h1);
    chk("align_alu_w", alu_out_w,        32'h102);
    chk("align_rw_w",  32'(reg_write_w), 32'h0);
    tick(nop, 1'b0, 1'b0, 32'h0);
    chk("align_err_clr", 32'(addr_err_w), 32'h0);
`else
    tick(ld, 1'b0, 1'b0, 32'h0);
    chk("noalign_req",  32'(dmem_req), 32'h1);
    chk("noalign_addr", dmem_addr,     32'h102);
    tick(nop, 1'b0, 1'b1, 32'hCAFE_0102);
    tick(nop, 1'b0, 1'b0, 32'h0);
    chk("noalign_err",  32'(addr_err_w), 32'h0);
    chk("noalign_rdw",  read_data_w,     32'hCAFE_0102);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS32 pipeline; directly consumes the execute-stage outputs (ALU result, store data, destination register, control bits, branch target/zero).
- Contains the EX/MEM pipeline register, a data-memory request/ready handshake with stall generation, branch resolution (pc_src), and the MEM/WB pipeline register feeding writeback.
- Asserts stall_m while a data-memory access is outstanding; IF/ID/EX freeze on stall_m.

Parameters:
- DATA_W, 32, datapath and address width.
- REG_AW, 5, register-file index width.
- STALL_CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- alu_out_e  input  DATA_W  ALU result / memory address from execute.
- write_data_e  input  DATA_W  store data from execute.
- write_reg_e  input  REG_AW  destination register from execute.
- reg_write_e  input  1  register write enable from execute.
- mem_to_reg_e  input  1  load select from execute.
- mem_write_e  input  1  store enable from execute.
- branch_e  input  1  branch instruction flag from execute.
- zero_e  input  1  ALU zero flag from execute.
- pc_branch_e  input  DATA_W  branch target from execute.
- dmem_req  output  1  data-memory request valid.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  DATA_W  access address.
- dmem_wdata  output  DATA_W  store data.
- dmem_ready  input  1  memory accepts/completes the request this cycle.
- dmem_rdata  input  DATA_W  load data, valid when dmem_ready=1.
- stall_m  output  1  upstream freeze request.
- pc_src_m  output  1  branch taken.
- pc_branch_m  output  DATA_W  branch target.
- alu_out_w  output  DATA_W  ALU result to writeback.
- read_data_w  output  DATA_W  load data to writeback.
- write_reg_w  output  REG_AW  destination register to writeback.
- reg_write_w  output  1  register write enable to writeback.
- mem_to_reg_w  output  1  writeback mux select.
- addr_err_w  output  1  misaligned-access flag (optional feature).
- stall_cycles  output  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: all EX/MEM and MEM/WB register contents 0, FSM in M_IDLE, stall_cycles 0. Every output is therefore 0, including dmem_req, stall_m, pc_src_m, reg_write_w and addr_err_w.
- EX/MEM register (suffix _m): loads all *_e inputs each cycle when stall_m=0; holds when stall_m=1.
- mem_op_m = mem_to_reg_m | mem_write_m.
- Combinational outputs from the _m register:
  - dmem_addr = alu_out_m, dmem_wdata = write_data_m, dmem_we = mem_write_m.
  - pc_src_m = branch_m & zero_m; pc_branch_m = pc_branch_m register.
- FSM states:
  - M_IDLE: dmem_req = mem_op_m. If mem_op_m & !dmem_ready, go to M_WAIT. Otherwise stay.
  - M_WAIT: dmem_req = 1. Stay until dmem_ready=1, then return to M_IDLE.
  - A zero-wait memory (ready in the same cycle as req) never leaves M_IDLE.
- stall_m = mem_op_m & dmem_req & !dmem_ready (combinational).
- Request stability: address, data and we are held stable while dmem_req=1 and dmem_ready=0.
- MEM/WB register (suffix _w), updated every cycle:
  - If stall_m=1: load a bubble (reg_write_w=0, mem_to_reg_w=0; data fields hold).
  - Else: alu_out_w←alu_out_m, write_reg_w←write_reg_m, reg_write_w←reg_write_m, mem_to_reg_w←mem_to_reg_m.
  - read_data_w←dmem_rdata when dmem_ready & !dmem_we, else hold.
- Load latency: load data appears on read_data_w 1 cycle after the dmem_ready cycle.
- Stores: write nothing to the register file unless reg_write_m=1.
- stall_cycles: increments each cycle stall_m=1; saturates at all-ones.
- Reset mid-access (M_WAIT): returns to M_IDLE next edge with dmem_req=0; the access is abandoned and the memory side ignores the late ready.
- Branch with pc_src_m=1 and a simultaneous stall: pc_src_m stays asserted throughout the stall, since the register is held.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: if mem_op_m=1 and alu_out_m[1:0]≠0:
  - dmem_req is suppressed and no stall occurs.
  - Next cycle: reg_write_w=0 and addr_err_w=1 for exactly one cycle.
  - alu_out_w carries the faulting address.
- Undefined: no checking; the address passes unmodified; addr_err_w is tied to 0.

Decomposition:
- Package mips_pkg holds:
  - mem_state_t enum {M_IDLE, M_WAIT}.
  - Constants XLEN=32 and REG_AW=5.
  - Struct ex_mem_t (the _m register fields) and struct mem_wb_t (the _w fields).
- One natural sub-module, mem_access_fsm: owns state, dmem_req, stall_m and stall_cycles. The top level holds the two pipeline registers.

Test Plan:
- Zero-wait load: alu_out_e=0x100, mem_to_reg_e=1, reg_write_e=1, write_reg_e=8, dmem_ready tied 1, dmem_rdata=0xDEADBEEF → dmem_req=1 for one cycle; next cycle read_data_w=0xDEADBEEF, write_reg_w=8, reg_write_w=1; stall_m never 1.
- 3-cycle-wait store: mem_write_e=1, alu_out_e=0x20, write_data_e=0x55; ready asserted on the 3rd req cycle → stall_m=1 for 2 cycles; addr/wdata stable; 2 bubbles with reg_write_w=0; stall_cycles=2.
- Branch: branch_e=1, zero_e=1, pc_branch_e=0x400040 → pc_src_m=1, pc_branch_m=0x400040 one cycle after capture; with zero_e=0, pc_src_m=0.
- Reset during M_WAIT: assert rst while dmem_ready=0 → next cycle dmem_req=0, stall_m=0, all _w outputs 0, stall_cycles=0.
- ALU op, no memory: reg_write_e=1, alu_out_e=0x7, write_reg_e=3 → next-next cycle alu_out_w=7, write_reg_w=3, mem_to_reg_w=0, dmem_req=0 throughout.
- MEM_ALIGN_CHECK_EN: load at 0x102 → dmem_req stays 0; addr_err_w=1 for one cycle, alu_out_w=0x102, reg_write_w=0.
